// File: rtl/clk_div_pkg.sv
// Shared constants for the programmable clock-divider bank.
// Ratios are expressed as input cycles per output period from the 50 MHz board clock.
package clk_div_pkg;

   localparam int unsigned MIN_DIV        = 2;
   localparam int unsigned DIV_50M_TO_1K  = 50000;
   localparam int unsigned DIV_50M_TO_1M  = 50;
   localparam int unsigned DIV_50M_TO_25M = 2;

   function automatic int unsigned sel_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Divisor write port of the clock-divider bank: write strobe, channel select,
// divisor value, and the per-channel pending flags returned by the bank.
interface clk_div_bank_if
   import clk_div_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 16,
   parameter int unsigned SEL_W  = sel_width(NUM_CH)
) ();

   logic              div_wr;
   logic [SEL_W-1:0]  div_sel;
   logic [CNT_W-1:0]  div_val;
   logic [NUM_CH-1:0] div_pending;

   modport master (output div_wr, div_sel, div_val, input div_pending);
   modport slave  (input div_wr, div_sel, div_val, output div_pending);

endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: registered divided clock plus a tick strobe on each rising edge.
// Divisor changes and parking only take effect at a period boundary.
module clk_div_ch
   import clk_div_pkg::*;
#(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned DEFAULT_DIV = 50
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             en,
   input  logic             wr,
   input  logic [CNT_W-1:0] wr_val,
   input  logic             restart,
   output logic             clk_out,
   output logic             tick,
   output logic             pending
);

   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] div_act;
   logic [CNT_W-1:0] div_pend;
   logic             pend_vld;
   logic [CNT_W-1:0] next_div;
   logic [CNT_W-1:0] cnt_inc;
   logic             wrap;

   always_comb begin
      next_div = pend_vld ? div_pend : div_act;
      cnt_inc  = cnt + ONE;
      wrap     = (cnt == div_act - ONE);
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= RST_DIV - ONE;
         div_act  <= RST_DIV;
         div_pend <= RST_DIV;
         pend_vld <= 1'b0;
         clk_out  <= 1'b0;
         tick     <= 1'b0;
      end else begin
         // Restart and parking both leave cnt at the last count of the (possibly new)
         // period, so the next enabled cycle wraps and produces the rising edge.
         if (restart || (wrap && !en)) begin
            div_act  <= next_div;
            pend_vld <= 1'b0;
            cnt      <= next_div - ONE;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
         end else if (wrap) begin
            div_act  <= next_div;
            pend_vld <= 1'b0;
            cnt      <= '0;
            clk_out  <= 1'b1;
            tick     <= 1'b1;
         end else begin
            cnt      <= cnt_inc;
            clk_out  <= (cnt_inc < (div_act >> 1));
            tick     <= 1'b0;
         end
         // A write in a boundary cycle must survive the clear above.
         if (wr) begin
            div_pend <= wr_val;
            pend_vld <= 1'b1;
         end
      end
   end

   assign pending = pend_vld;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH programmable clock dividers: decodes and clamps divisor writes,
// then fans them out to independent channels sharing a group phase restart.
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned DEFAULT_DIV = 50,
   parameter int unsigned SEL_W       = sel_width(NUM_CH)
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic              sync_restart,
   clk_div_bank_if.slave     bus,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick
);

   localparam logic [CNT_W-1:0] MIN_V = CNT_W'(MIN_DIV);

   logic [CNT_W-1:0] wr_val;

   always_comb begin
      wr_val = (bus.div_val < MIN_V) ? MIN_V : bus.div_val;
   end

   // Selects at or above NUM_CH match no channel and are dropped.
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic wr_i;
      assign wr_i = bus.div_wr && (bus.div_sel == SEL_W'(i));

      clk_div_ch #(
         .CNT_W       (CNT_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk_in  (clk_in),
         .rst_n   (rst_n),
         .en      (ch_en[i]),
         .wr      (wr_i),
         .wr_val  (wr_val),
         .restart (sync_restart),
         .clk_out (clk_out[i]),
         .tick    (tick[i]),
         .pending (bus.div_pending[i])
      );
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: a waveform-level reference predicts each cycle's
// outputs into a scoreboard queue, popped and compared after every clock edge.
module tb_clk_div_bank;

   logic       clk_in;
   logic       rst_n;
   logic [3:0] ch_en;
   logic       sync_restart;
   logic [3:0] clk_out;
   logic [3:0] tick;

   logic [2:0] ch_en2;
   logic       sync_restart2;
   logic [2:0] clk_out2;
   logic [2:0] tick2;

   clk_div_bank_if #(.NUM_CH(4), .CNT_W(16)) bus ();
   clk_div_bank_if #(.NUM_CH(3), .CNT_W(8))  bus2 ();

   clk_div_bank #(.NUM_CH(4), .CNT_W(16), .DEFAULT_DIV(50)) dut (
      .clk_in       (clk_in),
      .rst_n        (rst_n),
      .ch_en        (ch_en),
      .sync_restart (sync_restart),
      .bus          (bus.slave),
      .clk_out      (clk_out),
      .tick         (tick)
   );

   clk_div_bank #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(4)) dut2 (
      .clk_in       (clk_in),
      .rst_n        (rst_n),
      .ch_en        (ch_en2),
      .sync_restart (sync_restart2),
      .bus          (bus2.slave),
      .clk_out      (clk_out2),
      .tick         (tick2)
   );

   always #10 clk_in = ~clk_in;

   typedef struct {
      logic [3:0] co;
      logic [3:0] tk;
      logic [3:0] pd;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference: position since the last rising edge, period length, pending divisor.
   int m_pos[4];
   int m_d[4];
   int m_pend[4];
   bit m_pv[4];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_d[i]    = 50;
         m_pend[i] = 50;
         m_pv[i]   = 1'b0;
         m_pos[i]  = 49;
      end
   endtask

   task automatic cyc(input bit wr = 1'b0, input int sel = 0, input int val = 0,
                      input bit rs = 1'b0);
      exp_t e;
      logic [31:0] sel_v;
      logic [31:0] val_v;
      sel_v = sel;
      val_v = val;
      bus.div_wr   = wr;
      bus.div_sel  = sel_v[1:0];
      bus.div_val  = val_v[15:0];
      sync_restart = rs;
      for (int i = 0; i < 4; i++) begin
         if (rs) begin
            if (m_pv[i]) m_d[i] = m_pend[i];
            m_pv[i]  = 1'b0;
            m_pos[i] = m_d[i] - 1;
         end else if (m_pos[i] == m_d[i] - 1) begin
            if (m_pv[i]) m_d[i] = m_pend[i];
            m_pv[i]  = 1'b0;
            m_pos[i] = ch_en[i] ? 0 : m_d[i] - 1;
         end else begin
            m_pos[i]++;
         end
         if (wr && sel == i) begin
            m_pend[i] = (val < 2) ? 2 : val;
            m_pv[i]   = 1'b1;
         end
         e.co[i] = (m_pos[i] < m_d[i] / 2);
         e.tk[i] = (m_pos[i] == 0);
         e.pd[i] = m_pv[i];
      end
      sb.push_back(e);
      @(posedge clk_in);
      #1;
      bus.div_wr   = 1'b0;
      sync_restart = 1'b0;
      e = sb.pop_front();
      chk("clk_out", 32'(clk_out), 32'(e.co));
      chk("tick", 32'(tick), 32'(e.tk));
      chk("div_pending", 32'(bus.div_pending), 32'(e.pd));
   endtask

   initial begin
      clk_in        = 1'b0;
      rst_n         = 1'b0;
      ch_en         = 4'hF;
      sync_restart  = 1'b0;
      bus.div_wr    = 1'b0;
      bus.div_sel   = '0;
      bus.div_val   = '0;
      ch_en2        = '1;
      sync_restart2 = 1'b0;
      bus2.div_wr   = 1'b0;
      bus2.div_sel  = '0;
      bus2.div_val  = '0;
      model_reset();

      #25;
      chk("reset_clk_out", 32'(clk_out), 32'h0);
      chk("reset_tick", 32'(tick), 32'h0);
      chk("reset_pending", 32'(bus.div_pending), 32'h0);
      chk("reset_clk_out2", 32'(clk_out2), 32'h0);
      @(negedge clk_in);
      rst_n = 1'b1;

      // First edge after reset release wraps every enabled channel.
      cyc();
      chk("first_rise", 32'(clk_out), 32'hF);
      chk("first_rise2", 32'(clk_out2), 32'h7);
      chk("first_tick2", 32'(tick2), 32'h7);

      // Out-of-range select on a 3-channel bank must not touch any channel.
      bus2.div_wr  = 1'b1;
      bus2.div_sel = 2'd3;
      bus2.div_val = 8'd3;
      cyc();
      bus2.div_wr = 1'b0;
      chk("bad_sel_pending", 32'(bus2.div_pending), 32'h0);
      bus2.div_wr  = 1'b1;
      bus2.div_sel = 2'd2;
      bus2.div_val = 8'd1;
      cyc();
      bus2.div_wr = 1'b0;
      chk("good_sel_pending", 32'(bus2.div_pending), 32'h4);

      repeat (57) cyc();

      // Mid-period writes to ch1: last one wins at the boundary.
      cyc(1'b1, 1, 7);
      repeat (5) cyc();
      cyc(1'b1, 1, 5);
      repeat (60) cyc();

      // Park ch2 at position 10 of a 50-cycle period, then re-enable.
      for (int k = 0; k < 100 && m_pos[2] != 10; k++) cyc();
      if (m_pos[2] != 10) begin
         errors++;
         $display("FAIL park_wait: observed pos %0d expected 10", m_pos[2]);
      end
      ch_en[2] = 1'b0;
      repeat (50) cyc();
      ch_en[2] = 1'b1;
      cyc();
      chk("reenable_rise", 32'(clk_out[2]), 32'h1);
      repeat (10) cyc();

      // Group restart with a write to ch3 in the same cycle.
      cyc(1'b1, 0, 4);
      cyc(1'b1, 1, 6);
      repeat (60) cyc();
      cyc(1'b1, 3, 9, 1'b1);
      chk("restart_low", 32'(clk_out[1:0]), 32'h0);
      cyc();
      chk("restart_rise", 32'(clk_out[1:0]), 32'h3);
      repeat (30) cyc();

      // Divisors below the minimum clamp to 2.
      cyc(1'b1, 2, 0);
      cyc(1'b1, 3, 1);
      repeat (60) cyc();

      // Asynchronous reset in the high phase of a D=9 period.
      cyc(1'b1, 0, 9);
      for (int k = 0; k < 40 && !(m_d[0] == 9 && m_pos[0] == 1); k++) cyc();
      if (!(m_d[0] == 9 && m_pos[0] == 1)) begin
         errors++;
         $display("FAIL d9_wait: observed pos %0d expected 1", m_pos[0]);
      end
      chk("d9_high", 32'(clk_out[0]), 32'h1);
      #4;
      rst_n = 1'b0;
      #1;
      chk("async_clk_out", 32'(clk_out), 32'h0);
      chk("async_tick", 32'(tick), 32'h0);
      chk("async_pending", 32'(bus.div_pending), 32'h0);
      model_reset();
      @(negedge clk_in);
      rst_n = 1'b1;
      cyc();
      chk("rerise", 32'(clk_out), 32'hF);
      repeat (55) cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
